// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory port: access-size codes, controller
// FSM states, default window placement and the alignment rule.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_X = 2'd3;

  localparam int unsigned DEF_ADDR_W = 11;
  localparam logic [31:0] DEF_BASE   = 32'h1001_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Size 3 is never a legal access, whatever the address.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = lane[0];
      SZ_W:    mis = (lane != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data-memory port: byte enables and replicated
// store data on the write side, lane extraction plus extension on the read side.
module dmem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed byte and halfword out of the stored word.
  always_comb begin
    byte_s = 8'h00;
    case (lane_i)
      2'd0:    byte_s = rword_i[7:0];
      2'd1:    byte_s = rword_i[15:8];
      2'd2:    byte_s = rword_i[23:16];
      2'd3:    byte_s = rword_i[31:24];
      default: byte_s = 8'h00;
    endcase
    if (lane_i[1]) begin
      half_s = rword_i[31:16];
    end else begin
      half_s = rword_i[15:0];
    end
  end

  // Enables, replicated write data and extended read data per access size.
  always_comb begin
    be_o    = 4'b0000;
    wdata_o = 32'h0000_0000;
    rdata_o = 32'h0000_0000;
    case (size_i)
      SZ_B: begin
        be_o    = 4'b0001 << lane_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{signed_i & byte_s[7]}}, byte_s};
      end
      SZ_H: begin
        if (lane_i[1]) begin
          be_o = 4'b1100;
        end else begin
          be_o = 4'b0011;
        end
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{signed_i & half_s[15]}}, half_s};
      end
      SZ_W: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rword_i;
      end
      default: begin
        be_o    = 4'b0000;
        wdata_o = 32'h0000_0000;
        rdata_o = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/dmem_port_ctrl.sv
// Data-memory port controller: window decode, sized access with extension,
// error completion, configurable read latency and a stall-producing handshake.
module dmem_port_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter logic [31:0] BASE   = DEF_BASE,
  parameter int unsigned RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        err_misalign,
  output logic        err_range,
  output logic        stall
);

  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam logic [32:0] SPAN     = 33'd4 << ADDR_W;
  localparam int unsigned WAIT_CYC = (RD_LAT > 1) ? RD_LAT - 2 : 0;
  localparam logic [2:0]  CNT_INIT = WAIT_CYC[2:0];

  logic [31:0] mem_q [DEPTH];

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] hold_q, hold_d;
  logic        ready_q, ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        err_mis_q, err_mis_d;
  logic        err_rng_q, err_rng_d;

  logic [31:0]       off_s;
  logic [ADDR_W-1:0] idx_s;
  logic [1:0]        lane_s;
  logic              mis_s;
  logic              rng_s;
  logic              err_s;
  logic              accept_s;
  logic              mem_we_s;
  logic [31:0]       rword_s;
  logic [3:0]        be_s;
  logic [31:0]       wdata_rep_s;
  logic [31:0]       rdata_ext_s;

  // Addresses below BASE wrap to a huge offset and so fall out of range.
  assign off_s    = req_addr - BASE;
  assign idx_s    = off_s[ADDR_W+1:2];
  assign lane_s   = off_s[1:0];
  assign mis_s    = is_misaligned(req_size, lane_s);
  assign rng_s    = ({1'b0, off_s} >= SPAN);
  assign err_s    = mis_s | rng_s;
  assign accept_s = req_valid & ready_q;
  assign rword_s  = mem_q[idx_s];

  dmem_lane_align u_align (
    .lane_i   (lane_s),
    .size_i   (req_size),
    .signed_i (req_signed),
    .wdata_i  (req_wdata),
    .rword_i  (rword_s),
    .be_o     (be_s),
    .wdata_o  (wdata_rep_s),
    .rdata_o  (rdata_ext_s)
  );

  // Next-state, latency counter and response decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0000_0000;
    err_mis_d   = 1'b0;
    err_rng_d   = 1'b0;
    mem_we_s    = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = hold_q;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_IDLE, ST_RESP: begin
        state_d = ST_IDLE;
        if (accept_s) begin
          if (err_s) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            err_mis_d   = mis_s;
            err_rng_d   = rng_s;
          end else if (req_we) begin
            mem_we_s = 1'b1;
          end else if (RD_LAT == 32'd1) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = rdata_ext_s;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
            hold_d  = rdata_ext_s;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d != ST_WAIT);
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      hold_q      <= 32'h0000_0000;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      err_mis_q   <= 1'b0;
      err_rng_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      err_mis_q   <= err_mis_d;
      err_rng_q   <= err_rng_d;
    end
  end

  // Storage array: byte-lane writes, contents survive reset.
  always_ff @(posedge clk) begin
    if (rst && mem_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_q[idx_s][8*i +: 8] <= wdata_rep_s[8*i +: 8];
        end
      end
    end
  end

  assign req_ready    = ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign err_misalign = err_mis_q;
  assign err_range    = err_rng_q;
  assign stall        = req_valid & ~ready_q;

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// Bench for dmem_port_ctrl: three builds (RD_LAT 2, 1, 4) checked every cycle
// against a byte-level memory model, plus directed literal expectations.
module tb_dmem_port_ctrl;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rv = 1'b0;
  logic [2:0]  en = 3'b000;
  logic        we = 1'b0;
  logic [1:0]  sz = 2'd0;
  logic        sg = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wd = 32'h0;

  logic [2:0]  rv_w;
  logic [2:0]  rdy_w, vld_w, mis_w, rng_w, stl_w;
  logic [95:0] rdat_w;

  int n_checks = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  assign rv_w = {3{rv}} & en;

  always #5 clk = ~clk;

  dmem_port_ctrl #(.ADDR_W(11), .BASE(BASE), .RD_LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .req_valid(rv_w[0]), .req_we(we), .req_size(sz),
    .req_signed(sg), .req_addr(addr), .req_wdata(wd), .req_ready(rdy_w[0]),
    .rsp_valid(vld_w[0]), .rsp_rdata(rdat_w[31:0]), .err_misalign(mis_w[0]),
    .err_range(rng_w[0]), .stall(stl_w[0]));

  dmem_port_ctrl #(.ADDR_W(11), .BASE(BASE), .RD_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .req_valid(rv_w[1]), .req_we(we), .req_size(sz),
    .req_signed(sg), .req_addr(addr), .req_wdata(wd), .req_ready(rdy_w[1]),
    .rsp_valid(vld_w[1]), .rsp_rdata(rdat_w[63:32]), .err_misalign(mis_w[1]),
    .err_range(rng_w[1]), .stall(stl_w[1]));

  dmem_port_ctrl #(.ADDR_W(11), .BASE(BASE), .RD_LAT(4)) u_lat4 (
    .clk(clk), .rst(rst), .req_valid(rv_w[2]), .req_we(we), .req_size(sz),
    .req_signed(sg), .req_addr(addr), .req_wdata(wd), .req_ready(rdy_w[2]),
    .rsp_valid(vld_w[2]), .rsp_rdata(rdat_w[95:64]), .err_misalign(mis_w[2]),
    .err_range(rng_w[2]), .stall(stl_w[2]));

  function automatic int lat_of(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err < 40) $display("FAIL %s[lat%0d] at %0t: got %h expected %h", name, lat_of(k), $time, act, exp);
    end
  endtask

  // Reference model: byte memory per build, remaining cycles until the load data is due.
  logic [7:0]  mm [int];
  logic [2:0]  m_ready = 3'b111, m_valid = 3'b000, m_mis = 3'b000, m_rng = 3'b000;
  logic [31:0] m_data [3];
  logic [31:0] m_hold [3];
  int          m_rem [3];

  function automatic logic [31:0] mload(input int k, input logic [31:0] off, input logic [1:0] s, input logic sgn);
    int b;
    logic [7:0] b0, b1, b2, b3;
    b  = k * 65536 + int'(off);
    b0 = mm[b];
    if (s == 2'd0) return sgn ? {{24{b0[7]}}, b0} : {24'd0, b0};
    b1 = mm[b + 1];
    if (s == 2'd1) return sgn ? {{16{b1[7]}}, b1, b0} : {16'd0, b1, b0};
    b2 = mm[b + 2];
    b3 = mm[b + 3];
    return {b3, b2, b1, b0};
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic acc, bad_r, bad_m;
      logic [31:0] off;
      acc = rv_w[k] & m_ready[k];
      off = addr - BASE;
      bad_r = (off >= 32'h0000_2000);
      bad_m = (sz == 2'd3) || (sz == 2'd1 && off[0]) || (sz == 2'd2 && off[1:0] != 2'd0);
      m_valid[k] = 1'b0; m_mis[k] = 1'b0; m_rng[k] = 1'b0; m_data[k] = 32'h0;
      if (!rst) begin
        m_ready[k] = 1'b1;
        m_rem[k] = 0;
      end else if (acc && (bad_r || bad_m)) begin
        m_valid[k] = 1'b1; m_mis[k] = bad_m; m_rng[k] = bad_r; m_ready[k] = 1'b1;
      end else if (acc && we) begin
        for (int j = 0; j < (1 << sz); j++) mm[k * 65536 + int'(off) + j] = wd[8*j +: 8];
        m_ready[k] = 1'b1;
      end else if (acc) begin
        m_hold[k] = mload(k, off, sz, sg);
        m_rem[k] = lat_of(k) - 1;
        if (m_rem[k] == 0) begin
          m_valid[k] = 1'b1; m_data[k] = m_hold[k]; m_ready[k] = 1'b1;
        end else begin
          m_ready[k] = 1'b0;
        end
      end else if (m_rem[k] > 0) begin
        m_rem[k]--;
        if (m_rem[k] == 0) begin
          m_valid[k] = 1'b1; m_data[k] = m_hold[k]; m_ready[k] = 1'b1;
        end
      end else begin
        m_ready[k] = 1'b1;
      end
    end
    if (!rst) chk_on = 1'b1;
  end

  // Per-cycle comparison of every build against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 3; k++) begin
        chk("req_ready", k, 32'(rdy_w[k]), 32'(m_ready[k]));
        chk("rsp_valid", k, 32'(vld_w[k]), 32'(m_valid[k]));
        chk("err_misalign", k, 32'(mis_w[k]), 32'(m_mis[k]));
        chk("err_range", k, 32'(rng_w[k]), 32'(m_rng[k]));
        chk("stall", k, 32'(stl_w[k]), 32'(rv_w[k] & ~m_ready[k]));
        if (m_valid[k]) chk("rsp_rdata", k, rdat_w[32*k +: 32], m_data[k]);
      end
    end
  end

  // One request to the enabled builds, then a fixed window for the response.
  task automatic run(input logic [2:0] en_i, input logic we_i, input logic [1:0] sz_i,
                     input logic sg_i, input logic [31:0] a_i, input logic [31:0] wd_i,
                     input bit rsp, input logic [31:0] exp_d, input bit em, input bit er);
    int first [3];
    logic [31:0] gd [3];
    logic [2:0] gm, gr;
    first = '{0, 0, 0};
    gm = 3'b000; gr = 3'b000;
    @(posedge clk); #1;
    en = en_i; rv = 1'b1; we = we_i; sz = sz_i; sg = sg_i; addr = a_i; wd = wd_i;
    @(posedge clk); #1;
    rv = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (en_i[k] && vld_w[k] && first[k] == 0) begin
          first[k] = n; gd[k] = rdat_w[32*k +: 32]; gm[k] = mis_w[k]; gr[k] = rng_w[k];
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (en_i[k]) begin
        if (rsp) begin
          chk("latency", k, 32'(first[k]), (em || er) ? 32'd1 : 32'(lat_of(k)));
          chk("lit_rdata", k, gd[k], exp_d);
          chk("lit_mis", k, 32'(gm[k]), 32'(em));
          chk("lit_rng", k, 32'(gr[k]), 32'(er));
        end else begin
          chk("no_rsp", k, 32'(first[k]), 32'd0);
        end
      end
    end
  endtask

  initial begin
    logic [5:0] vpat, spat;
    int cnt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", k, 32'(rdy_w[k]), 32'd1);
      chk("rst_valid", k, 32'(vld_w[k]), 32'd0);
      chk("rst_rdata", k, rdat_w[32*k +: 32], 32'h0);
      chk("rst_err", k, 32'({mis_w[k], rng_w[k]}), 32'd0);
    end
    @(posedge clk); #1 rst = 1'b1;

    run(3'b111, 1'b1, 2'd2, 1'b0, 32'h1001_0004, 32'hA1B2_C3D4, 1'b0, 32'h0, 1'b0, 1'b0);
    run(3'b111, 1'b0, 2'd2, 1'b0, 32'h1001_0004, 32'h0, 1'b1, 32'hA1B2_C3D4, 1'b0, 1'b0);
    run(3'b111, 1'b1, 2'd0, 1'b0, 32'h1001_0005, 32'h0000_00FF, 1'b0, 32'h0, 1'b0, 1'b0);
    run(3'b111, 1'b0, 2'd0, 1'b1, 32'h1001_0005, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run(3'b111, 1'b0, 2'd0, 1'b0, 32'h1001_0005, 32'h0, 1'b1, 32'h0000_00FF, 1'b0, 1'b0);
    run(3'b111, 1'b0, 2'd2, 1'b0, 32'h1001_0004, 32'h0, 1'b1, 32'hA1B2_FFD4, 1'b0, 1'b0);
    run(3'b111, 1'b0, 2'd1, 1'b0, 32'h1001_0006, 32'h0, 1'b1, 32'h0000_A1B2, 1'b0, 1'b0);
    run(3'b111, 1'b0, 2'd1, 1'b1, 32'h1001_0006, 32'h0, 1'b1, 32'hFFFF_A1B2, 1'b0, 1'b0);
    run(3'b111, 1'b0, 2'd2, 1'b1, 32'h1001_0004, 32'h0, 1'b1, 32'hA1B2_FFD4, 1'b0, 1'b0);
    run(3'b111, 1'b0, 2'd1, 1'b1, 32'h1001_0003, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
    run(3'b111, 1'b1, 2'd2, 1'b0, 32'h1001_1FFC, 32'h5A5A_0001, 1'b0, 32'h0, 1'b0, 1'b0);
    run(3'b111, 1'b1, 2'd2, 1'b0, 32'h1000_FFFC, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0, 1'b1);
    run(3'b111, 1'b0, 2'd2, 1'b0, 32'h1001_1FFC, 32'h0, 1'b1, 32'h5A5A_0001, 1'b0, 1'b0);
    run(3'b111, 1'b1, 2'd2, 1'b0, 32'h1001_0000, 32'h0123_4567, 1'b0, 32'h0, 1'b0, 1'b0);
    run(3'b111, 1'b1, 2'd2, 1'b0, 32'h1001_2000, 32'hCAFE_F00D, 1'b1, 32'h0, 1'b0, 1'b1);
    run(3'b111, 1'b0, 2'd2, 1'b0, 32'h1001_0000, 32'h0, 1'b1, 32'h0123_4567, 1'b0, 1'b0);
    run(3'b111, 1'b0, 2'd1, 1'b0, 32'h1000_FFFF, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1);
    run(3'b111, 1'b0, 2'd3, 1'b0, 32'h1001_0000, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
    run(3'b111, 1'b1, 2'd2, 1'b0, 32'h1001_0008, 32'h0000_0000, 1'b0, 32'h0, 1'b0, 1'b0);
    run(3'b111, 1'b1, 2'd1, 1'b0, 32'h1001_000A, 32'h1234_BEEF, 1'b0, 32'h0, 1'b0, 1'b0);
    run(3'b111, 1'b0, 2'd2, 1'b0, 32'h1001_0008, 32'h0, 1'b1, 32'hBEEF_0000, 1'b0, 1'b0);
    run(3'b111, 1'b1, 2'd0, 1'b0, 32'h1001_0008, 32'h0000_0077, 1'b0, 32'h0, 1'b0, 1'b0);
    run(3'b111, 1'b0, 2'd2, 1'b0, 32'h1001_0008, 32'h0, 1'b1, 32'hBEEF_0077, 1'b0, 1'b0);

    // Back-to-back loads on the RD_LAT=2 build with req_valid held.
    @(posedge clk); #1;
    en = 3'b001; rv = 1'b1; we = 1'b0; sz = 2'd2; sg = 1'b0; addr = 32'h1001_0004;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      vpat[n] = vld_w[0];
      spat[n] = stl_w[0];
      @(posedge clk); #1;
      if (n == 2) rv = 1'b0;
    end
    chk("b2b_valid_pattern", 0, 32'(vpat), 32'b010100);
    chk("b2b_stall_pattern", 0, 32'(spat), 32'b000010);
    repeat (3) @(posedge clk);

    // Reset while a read is pending.
    #1;
    en = 3'b111; rv = 1'b1; we = 1'b0; sz = 2'd2; addr = 32'h1001_0004;
    @(posedge clk); #1;
    rv = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", 0, 32'(rdy_w), 32'b111);
    chk("rst_mid_valid", 0, 32'(vld_w), 32'b000);
    cnt = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (vld_w != 3'b000) cnt++;
    end
    chk("rst_mid_no_rsp", 0, 32'(cnt), 32'd0);
    run(3'b111, 1'b0, 2'd2, 1'b0, 32'h1001_0004, 32'h0, 1'b1, 32'hA1B2_FFD4, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
